day5_range_ctrl: RTL and testbench

// Front-end controller for the day-5 range-merge solver. Accepts a stream of
// [start,end] ranges and writes them into the solver's range tables. Pads any

---
 rtl/day5_range_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_day5_range_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day5_range_ctrl.sv
// Front-end controller for the day-5 range-merge solver: loads and pads the
// range tables, kicks the solver, and hands back its result or an error code.
module day5_range_ctrl #(
    parameter int NUM_RANGE = 182,
    parameter int WIDTH     = 50,
    parameter int TIMEOUT   = 4096,
    localparam int ADDR_W   = (NUM_RANGE > 1) ? $clog2(NUM_RANGE) : 1,
    localparam int CNT_W    = $clog2(NUM_RANGE + 1)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_start,
    input  logic [WIDTH-1:0]  in_end,
    input  logic              in_last,

    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_start,
    output logic [WIDTH-1:0]  wr_end,

    output logic              solver_rst,
    output logic              solver_start,
    input  logic              solver_finished,
    input  logic [63:0]       solver_result,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_data,
    output logic [CNT_W-1:0]  res_count,

    output logic              err_valid,
    output logic [1:0]        err_code,
    input  logic              err_clear
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_MALFORMED = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    typedef enum logic [2:0] {
        S_LOAD,
        S_PAD,
        S_CLR,
        S_KICK,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] pad_addr_q, pad_addr_d;
    logic [WIDTH-1:0]  pad_start_q, pad_start_d;
    logic [WIDTH-1:0]  pad_end_q, pad_end_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_start_q, wr_start_d;
    logic [WIDTH-1:0]  wr_end_q, wr_end_d;
    logic              solver_rst_q, solver_rst_d;
    logic              solver_start_q, solver_start_d;
    logic              res_valid_q, res_valid_d;
    logic [63:0]       res_data_q, res_data_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic              table_full;

    assign in_ready   = (state_q == S_LOAD);
    assign accept     = in_valid && in_ready;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign table_full = (cnt_inc == CNT_W'(NUM_RANGE));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        pad_addr_d     = pad_addr_q;
        pad_start_d    = pad_start_q;
        pad_end_d      = pad_end_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_start_d     = wr_start_q;
        wr_end_d       = wr_end_q;
        solver_rst_d   = 1'b0;
        solver_start_d = 1'b0;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;
        err_valid_d    = err_valid_q;
        err_code_d     = err_code_q;

        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (in_start > in_end) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_MALFORMED;
                        state_d     = S_ERR;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_W'(cnt_q);
                        wr_start_d = in_start;
                        wr_end_d   = in_end;
                        cnt_d      = cnt_inc;
                        if (in_last && !table_full) begin
                            // Duplicating the last range leaves the merge result unchanged.
                            pad_start_d = in_start;
                            pad_end_d   = in_end;
                            pad_addr_d  = ADDR_W'(cnt_inc);
                            state_d     = S_PAD;
                        end else if (in_last) begin
                            state_d = S_CLR;
                        end else if (table_full) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_OVERFLOW;
                            state_d     = S_ERR;
                        end
                    end
                end
            end

            S_PAD: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = pad_addr_q;
                wr_start_d = pad_start_q;
                wr_end_d   = pad_end_q;
                if (pad_addr_q == ADDR_W'(NUM_RANGE - 1)) begin
                    state_d = S_CLR;
                end else begin
                    pad_addr_d = pad_addr_q + ADDR_W'(1);
                end
            end

            S_CLR: begin
                solver_rst_d = 1'b1;
                state_d      = S_KICK;
            end

            S_KICK: begin
                solver_start_d = 1'b1;
                timer_d        = '0;
                state_d        = S_WAIT;
            end

            S_WAIT: begin
                if (solver_finished) begin
                    res_data_d  = solver_result;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_LOAD;
                end
            end

            S_ERR: begin
                if (err_clear) begin
                    err_valid_d = 1'b0;
                    err_code_d  = 2'd0;
                    cnt_d       = '0;
                    state_d     = S_LOAD;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_LOAD;
            cnt_q          <= '0;
            timer_q        <= '0;
            pad_addr_q     <= '0;
            pad_start_q    <= '0;
            pad_end_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_start_q     <= '0;
            wr_end_q       <= '0;
            solver_rst_q   <= 1'b0;
            solver_start_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= 2'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            pad_addr_q     <= pad_addr_d;
            pad_start_q    <= pad_start_d;
            pad_end_q      <= pad_end_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_start_q     <= wr_start_d;
            wr_end_q       <= wr_end_d;
            solver_rst_q   <= solver_rst_d;
            solver_start_q <= solver_start_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_start     = wr_start_q;
    assign wr_end       = wr_end_q;
    assign solver_rst   = solver_rst_q;
    assign solver_start = solver_start_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_count    = cnt_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_day5_range_ctrl.sv
// Directed bench for day5_range_ctrl with NUM_RANGE=8 and TIMEOUT=16.
// The solver is driven by hand from the stimulus sequence.
module tb_day5_range_ctrl;

    localparam int NR = 8;
    localparam int W  = 50;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_start;
    logic [W-1:0]  in_end;
    logic          in_last;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [W-1:0]  wr_start;
    logic [W-1:0]  wr_end;
    logic          solver_rst;
    logic          solver_start;
    logic          solver_finished;
    logic [63:0]   solver_result;
    logic          res_valid;
    logic          res_ready;
    logic [63:0]   res_data;
    logic [3:0]    res_count;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          err_clear;

    int checks = 0;
    int failures = 0;
    int nwr = 0;
    int base;
    int n;
    logic [W-1:0] ts [NR];
    logic [W-1:0] te [NR];

    day5_range_ctrl #(.NUM_RANGE(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_start(in_start), .in_end(in_end), .in_last(in_last),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_start(wr_start), .wr_end(wr_end),
        .solver_rst(solver_rst), .solver_start(solver_start),
        .solver_finished(solver_finished), .solver_result(solver_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_count(res_count),
        .err_valid(err_valid), .err_code(err_code), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    // Table model: capture every write away from the clock edge.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            ts[wr_addr] = wr_start;
            te[wr_addr] = wr_end;
            nwr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] e, input logic l);
        int k;
        in_valid = 1'b1;
        in_start = s;
        in_end   = e;
        in_last  = l;
        k = 0;
        while (!in_ready && k < 32) begin
            tick();
            k++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_rst(output int cyc);
        cyc = 0;
        while (!solver_rst && cyc < 64) begin
            tick();
            cyc++;
        end
        chk("solver_rst_seen", {63'd0, solver_rst}, 64'd1);
    endtask

    task automatic finish_job(input logic [63:0] r, input logic [63:0] cnt);
        tick();
        chk("start_pulse", {63'd0, solver_start}, 64'd1);
        chk("rst_pulse_one", {63'd0, solver_rst}, 64'd0);
        solver_result   = r;
        solver_finished = 1'b1;
        tick();
        solver_finished = 1'b0;
        chk("res_valid", {63'd0, res_valid}, 64'd1);
        chk("res_data", res_data, r);
        chk("res_count", {60'd0, res_count}, cnt);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("ready_after_resp", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_start = '0;
        in_end = '0;
        in_last = 1'b0;
        solver_finished = 1'b0;
        solver_result = '0;
        res_ready = 1'b0;
        err_clear = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_err_valid", {63'd0, err_valid}, 64'd0);
        chk("rst_res_count", {60'd0, res_count}, 64'd0);

        // Job 1: three ranges, padded with (12,18)
        base = nwr;
        send(3, 5, 1'b0);
        chk("j1_wr_en", {63'd0, wr_en}, 64'd1);
        chk("j1_wr_addr0", {61'd0, wr_addr}, 64'd0);
        chk("j1_wr_start0", {14'd0, wr_start}, 64'd3);
        chk("j1_wr_end0", {14'd0, wr_end}, 64'd5);
        send(10, 14, 1'b0);
        send(12, 18, 1'b1);
        chk("j1_wr_addr2", {61'd0, wr_addr}, 64'd2);
        wait_rst(n);
        chk("j1_rst_delay", 64'(n), 64'd6);
        chk("j1_writes", 64'(nwr - base), 64'd8);
        chk("j1_tbl1", {14'd0, ts[1]}, 64'd10);
        for (int i = 3; i < NR; i++) begin
            chk("j1_pad_start", {14'd0, ts[i]}, 64'd12);
            chk("j1_pad_end", {14'd0, te[i]}, 64'd18);
        end
        finish_job(64'd14, 64'd3);

        // Job 2: full table, no padding
        base = nwr;
        for (int i = 0; i < NR; i++)
            send(W'(i * 10), W'(i * 10 + 5), i == NR - 1);
        chk("j2_last_addr", {61'd0, wr_addr}, 64'd7);
        wait_rst(n);
        chk("j2_rst_delay", 64'(n), 64'd1);
        chk("j2_writes", 64'(nwr - base), 64'd8);
        chk("j2_tbl7_end", {14'd0, te[7]}, 64'd75);
        finish_job(64'h0123_4567_89ab_cdef, 64'd8);

        // Job 3: malformed second beat
        base = nwr;
        send(1, 2, 1'b0);
        send(9, 4, 1'b0);
        chk("j3_err_valid", {63'd0, err_valid}, 64'd1);
        chk("j3_err_code", {62'd0, err_code}, 64'd1);
        chk("j3_in_ready", {63'd0, in_ready}, 64'd0);
        chk("j3_no_wr", {63'd0, wr_en}, 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("j3_writes", 64'(nwr - base), 64'd1);
        chk("j3_err_held", {62'd0, err_code}, 64'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("j3_clr_valid", {63'd0, err_valid}, 64'd0);
        chk("j3_clr_code", {62'd0, err_code}, 64'd0);
        chk("j3_clr_ready", {63'd0, in_ready}, 64'd1);
        send(7, 7, 1'b1);
        chk("j3_restart_addr", {61'd0, wr_addr}, 64'd0);
        chk("j3_restart_wr", {63'd0, wr_en}, 64'd1);
        wait_rst(n);
        chk("j3_rst_delay", 64'(n), 64'd8);
        chk("j3_pad7", {14'd0, ts[7]}, 64'd7);
        finish_job(64'd77, 64'd1);

        // Job 4: overflow, ninth beat held off until cleared
        base = nwr;
        for (int i = 0; i < NR; i++)
            send(W'(i), W'(i + 1), 1'b0);
        chk("j4_err_valid", {63'd0, err_valid}, 64'd1);
        chk("j4_err_code", {62'd0, err_code}, 64'd2);
        in_valid = 1'b1;
        in_start = 20;
        in_end = 30;
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("j4_held_ready", {63'd0, in_ready}, 64'd0);
            chk("j4_held_wr", {63'd0, wr_en}, 64'd0);
        end
        chk("j4_writes", 64'(nwr - base), 64'd8);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("j4_clr_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("j4_9th_wr", {63'd0, wr_en}, 64'd1);
        chk("j4_9th_addr", {61'd0, wr_addr}, 64'd0);
        chk("j4_9th_start", {14'd0, wr_start}, 64'd20);
        wait_rst(n);
        chk("j4_rst_delay", 64'(n), 64'd8);
        finish_job(64'd5, 64'd1);

        // Job 5a: solver hangs
        for (int i = 0; i < NR; i++)
            send(W'(i), W'(i), i == NR - 1);
        wait_rst(n);
        tick();
        chk("j5_start", {63'd0, solver_start}, 64'd1);
        repeat (TO - 1) tick();
        chk("j5_no_err_yet", {63'd0, err_valid}, 64'd0);
        tick();
        chk("j5_err_valid", {63'd0, err_valid}, 64'd1);
        chk("j5_err_code", {62'd0, err_code}, 64'd3);
        chk("j5_no_res", {63'd0, res_valid}, 64'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("j5_clr_ready", {63'd0, in_ready}, 64'd1);

        // Job 5b: finish on the final allowed cycle
        for (int i = 0; i < NR; i++)
            send(W'(i), W'(i), i == NR - 1);
        wait_rst(n);
        tick();
        chk("j5b_start", {63'd0, solver_start}, 64'd1);
        repeat (TO - 1) tick();
        solver_result = 64'd99;
        solver_finished = 1'b1;
        tick();
        solver_finished = 1'b0;
        chk("j5b_res_valid", {63'd0, res_valid}, 64'd1);
        chk("j5b_res_data", res_data, 64'd99);
        chk("j5b_no_err", {63'd0, err_valid}, 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("j5b_done", {63'd0, res_valid}, 64'd0);

        // Job 6: back-pressured result, then reset mid-WAIT
        send(1, 1, 1'b1);
        wait_rst(n);
        tick();
        solver_result = 64'hdead_beef;
        solver_finished = 1'b1;
        tick();
        solver_finished = 1'b0;
        err_clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("j6_hold_valid", {63'd0, res_valid}, 64'd1);
            chk("j6_hold_data", res_data, 64'hdead_beef);
            chk("j6_hold_ready", {63'd0, in_ready}, 64'd0);
            chk("j6_hold_count", {60'd0, res_count}, 64'd1);
            tick();
        end
        err_clear = 1'b0;
        chk("j6_no_err", {63'd0, err_valid}, 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("j6_released", {63'd0, res_valid}, 64'd0);

        send(4, 6, 1'b1);
        wait_rst(n);
        tick();
        chk("j6_start", {63'd0, solver_start}, 64'd1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("j6_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("j6_rst_wr", {63'd0, wr_en}, 64'd0);
        chk("j6_rst_addr", {61'd0, wr_addr}, 64'd0);
        chk("j6_rst_srst", {63'd0, solver_rst}, 64'd0);
        chk("j6_rst_sstart", {63'd0, solver_start}, 64'd0);
        chk("j6_rst_resv", {63'd0, res_valid}, 64'd0);
        chk("j6_rst_data", res_data, 64'd0);
        chk("j6_rst_count", {60'd0, res_count}, 64'd0);
        chk("j6_rst_err", {63'd0, err_valid}, 64'd0);
        chk("j6_rst_code", {62'd0, err_code}, 64'd0);
        send(2, 3, 1'b1);
        chk("j6_after_addr", {61'd0, wr_addr}, 64'd0);
        wait_rst(n);
        chk("j6_after_delay", 64'(n), 64'd8);
        finish_job(64'd42, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
